// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus arbiter: source indices, default width, FSM states.
package bus_pkg;

  localparam int SRC_PC = 0;
  localparam int SRC_AR = 1;
  localparam int SRC_AC = 2;
  localparam int SRC_R  = 3;
  localparam int SRC_DM = 4;
  localparam int SRC_IM = 5;
  localparam int SRC_DR = 6;

  localparam int BUS_NUM_SRC  = 7;
  localparam int BUS_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter  int N  = 7,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Scan from the far end so the entry nearest i_ptr is written last and wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared bus with bounded hold and a dead cycle
// between owners; read_en is registered and one-hot or zero.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_SRC  = BUS_NUM_SRC,
  parameter  int MAX_HOLD = BUS_MAX_HOLD,
  localparam int IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] read_en,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx,
  output logic               preempt
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  bus_state_e         r_state, w_nxt_state;
  logic [NUM_SRC-1:0] r_read_en, w_read_en_nxt;
  logic [IW-1:0]      r_grant_idx, w_idx_nxt;
  logic               r_preempt, w_pre_nxt;
  logic [IW-1:0]      r_rr_ptr, w_ptr_nxt;
  logic [HW-1:0]      r_hold, w_hold_nxt;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic               w_own_req, w_others, w_hold_max, w_force;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // While granting, r_read_en is the owner's one-hot mask.
  assign w_own_req  = |(req & r_read_en);
  assign w_others   = |(req & ~r_read_en);
  assign w_hold_max = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD));
  assign w_force    = w_own_req && w_hold_max && w_others;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_read_en   <= '0;
      r_grant_idx <= '0;
      r_preempt   <= 1'b0;
      r_rr_ptr    <= '0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_read_en   <= w_read_en_nxt;
      r_grant_idx <= w_idx_nxt;
      r_preempt   <= w_pre_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE, ST_TURN: w_nxt_state = w_found ? ST_GRANT : ST_IDLE;
      ST_GRANT: begin
        if (!w_own_req || w_force) w_nxt_state = ST_TURN;
        else                       w_nxt_state = ST_GRANT;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_read_en_nxt = '0;
    w_idx_nxt     = r_grant_idx;
    w_pre_nxt     = 1'b0;
    w_ptr_nxt     = r_rr_ptr;
    w_hold_nxt    = r_hold;
    if (r_state == ST_GRANT) begin
      if (w_nxt_state == ST_GRANT) begin
        w_read_en_nxt = r_read_en;
        if (r_hold < HW'(MAX_HOLD)) w_hold_nxt = r_hold + HW'(1);
      end else begin
        // Release takes priority: preempt only flags a forced drop of a live request.
        w_pre_nxt = w_force;
      end
    end else if (w_found) begin
      w_read_en_nxt = NUM_SRC'(1) << w_win;
      w_idx_nxt     = w_win;
      w_hold_nxt    = HW'(1);
      w_ptr_nxt     = (w_win == IW'(NUM_SRC - 1)) ? '0 : w_win + IW'(1);
    end
  end

  assign read_en     = r_read_en;
  assign grant_valid = |r_read_en;
  assign grant_idx   = r_grant_idx;
  assign preempt     = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized + directed bench for bus_arbiter with a per-cycle scoreboard against an owner/pointer model.
module tb_bus_arbiter;

  localparam int NSRC = 7;
  localparam int MAXH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] req = '0;
  logic [NSRC-1:0] read_en;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic            preempt;

  bus_arbiter #(.NUM_SRC(NSRC), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .read_en     (read_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [NSRC-1:0] re;
    int              idx;
    bit              pre;
  } exp_t;

  exp_t q[$];

  // Reference: who owns the bus, how long, and where the next search starts.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_pre   = 0;

  initial forever begin
    exp_t e;
    bit   done;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
      q.delete();
    end else begin
      m_pre = 0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) m_owner = -1;
        else if (MAXH != 0 && m_hold == MAXH && (req & ~(7'd1 << m_owner)) != 0) begin
          m_owner = -1;
          m_pre   = 1;
        end else if (m_hold < MAXH) m_hold++;
      end else begin
        done = 0;
        for (int k = 0; k < NSRC; k++) begin
          int i;
          i = (m_ptr + k) % NSRC;
          if (!done && req[i]) begin
            done = 1; m_owner = i; m_last = i; m_hold = 1; m_ptr = (i + 1) % NSRC;
          end
        end
      end
      e.re  = (m_owner >= 0) ? (7'd1 << m_owner) : 7'd0;
      e.idx = m_last;
      e.pre = m_pre;
      q.push_back(e);
    end
  end

  logic [NSRC-1:0] prev_re = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) prev_re = '0;
    else begin
      if (q.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = q.pop_front();
        chk("read_en", int'(read_en), int'(e.re));
        chk("grant_valid", int'(grant_valid), int'(|e.re));
        chk("grant_idx", int'(grant_idx), e.idx);
        chk("preempt", int'(preempt), int'(e.pre));
      end
      chk("onehot0", int'($onehot0(read_en)), 1);
      chk("no_b2b_owner",
          int'(prev_re != 0 && read_en != 0 && prev_re != read_en), 0);
      prev_re = read_en;
    end
  end

  task automatic drive(input logic [NSRC-1:0] r, input int n);
    req = r;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [NSRC-1:0] r;
    #3;
    chk("rst_read_en", int'(read_en), 0);
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_grant_idx", int'(grant_idx), 0);
    chk("rst_preempt", int'(preempt), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    drive(7'b0000000, 10);
    drive(7'b0000100, 3);
    drive(7'b0000000, 4);
    drive(7'b1000001, 40);
    drive(7'b0000000, 3);
    drive(7'b1000000, 3);
    drive(7'b0000000, 2);
    drive(7'b1000001, 5);
    drive(7'b0000000, 3);
    drive(7'b0100000, 30);
    drive(7'b0000000, 3);

    // Async reset in the middle of a DM grant.
    drive(7'b0010000, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_read_en", int'(read_en), 0);
    chk("async_rst_grant_valid", int'(grant_valid), 0);
    chk("async_rst_grant_idx", int'(grant_idx), 0);
    req = 7'b0010001;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (6) @(negedge clk);
    drive(7'b0000000, 3);

    r = '0;
    repeat (400) begin
      r = r ^ NSRC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      drive(r, 1);
    end
    drive(7'b0000000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
